abs_deviation_monitor: RTL and testbench

Pipelined, parametrised absolute-deviation unit for the health-checking datapath. It accepts a stream of signed two's-complement vital-sign samples and computes |sample − nominal| per sample. It flags samples whose deviation exceeds a programmable threshold and raises a sticky alarm after HOLD consecutive over-threshold results. It sits between the sensor-sample front end and the alarm/report logic, and is the sequential, handshaked successor of the 8-bit combinational absolute-value block.

---
 rtl/abs_deviation_monitor_if.sv | 30 +++
 rtl/abs_deviation_monitor.sv | 128 ++++++++++++
 tb/tb_abs_deviation_monitor.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abs_deviation_monitor_if.sv
// Sample/result handshake bundle between the sensor front end, the
// deviation monitor and the alarm/report logic.
interface abs_deviation_monitor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] nominal;
  logic [WIDTH-1:0] threshold;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] abs_dev;
  logic             over;
  logic             alarm;
  logic [WIDTH-1:0] peak;

  // Producer/consumer side that drives samples and accepts results
  modport master (
    output in_valid, sample, nominal, threshold, clear, out_ready,
    input  in_ready, out_valid, abs_dev, over, alarm, peak
  );

  // Monitor side
  modport slave (
    input  in_valid, sample, nominal, threshold, clear, out_ready,
    output in_ready, out_valid, abs_dev, over, alarm, peak
  );
endinterface

// File: rtl/abs_deviation_monitor.sv
// Two-stage absolute-deviation monitor: |sample - nominal|, threshold
// flag, running peak and a sticky alarm after HOLD consecutive overs.
module abs_deviation_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  abs_deviation_monitor_if.slave bus
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PENDING = 2'd1,
    ST_ALARM   = 2'd2
  } state_e;

  logic             advance;
  logic [DW-1:0]    diff_d, diff_q;
  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] abs_w;
  logic             over_w;
  logic [WIDTH-1:0] abs_dev_d, abs_dev_q;
  logic             over_d, over_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] peak_d, peak_q;
  logic             alarm_d, alarm_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  state_e           state_d, state_q;

  // Both stages move together whenever the output slot is free or drained
  assign advance = !out_valid_q || bus.out_ready;

  // Magnitude of the stage-1 difference; the range never reaches -2^WIDTH,
  // so the low WIDTH bits of the negation are exact
  assign abs_w  = diff_q[WIDTH] ? (~diff_q[WIDTH-1:0] + WIDTH'(1)) : diff_q[WIDTH-1:0];
  assign over_w = abs_w > bus.threshold;

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.abs_dev   = abs_dev_q;
  assign bus.over      = over_q;
  assign bus.alarm     = alarm_q;
  assign bus.peak      = peak_q;

  // Datapath pipeline: stage 1 difference, stage 2 result registers
  always_comb begin
    s1_valid_d  = s1_valid_q;
    diff_d      = diff_q;
    out_valid_d = out_valid_q;
    abs_dev_d   = abs_dev_q;
    over_d      = over_q;
    if (advance) begin
      s1_valid_d  = bus.in_valid;
      diff_d      = {bus.sample[WIDTH-1], bus.sample} - {bus.nominal[WIDTH-1], bus.nominal};
      out_valid_d = s1_valid_q;
      abs_dev_d   = abs_w;
      over_d      = over_w;
    end
  end

  // Alarm FSM and peak tracker, stepped only by valid stage-2 loads
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    if (bus.clear) begin
      state_d = ST_NORMAL;
      cnt_d   = '0;
      peak_d  = '0;
    end else if (advance && s1_valid_q) begin
      if (abs_w > peak_q) peak_d = abs_w;
      case (state_q)
        ST_NORMAL: begin
          if (over_w) begin
            cnt_d   = CNT_W'(1);
            state_d = (HOLD_C == CNT_W'(1)) ? ST_ALARM : ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (over_w) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == HOLD_C) state_d = ST_ALARM;
          end else begin
            cnt_d   = '0;
            state_d = ST_NORMAL;
          end
        end
        ST_ALARM: cnt_d = HOLD_C;
        default: begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
    alarm_d = (state_d == ST_ALARM);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
      abs_dev_q   <= '0;
      over_q      <= 1'b0;
      peak_q      <= '0;
      alarm_q     <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_NORMAL;
    end else begin
      s1_valid_q  <= s1_valid_d;
      diff_q      <= diff_d;
      out_valid_q <= out_valid_d;
      abs_dev_q   <= abs_dev_d;
      over_q      <= over_d;
      peak_q      <= peak_d;
      alarm_q     <= alarm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_abs_deviation_monitor.sv
// Self-checking bench for abs_deviation_monitor: vector table, directed
// alarm/clear/reset/backpressure sequences and a randomized scoreboard run.
module tb_abs_deviation_monitor;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  abs_deviation_monitor_if #(.WIDTH(WIDTH)) bus ();

  abs_deviation_monitor #(.WIDTH(WIDTH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int exp_q[$];
  int alarm_log[$];
  int thr;
  int mpeak;
  int mrun;
  int malarm;
  int pops;
  bit sb_en;

  typedef struct {
    int s;
    int n;
    int th;
    int exp_abs;
    int exp_over;
    int exp_peak;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int absdev(input int s, input int n);
    return (s > n) ? (s - n) : (n - s);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    alarm_log.delete();
    mpeak  = 0;
    mrun   = 0;
    malarm = 0;
    pops   = 0;
  endtask

  task automatic drive(input bit v, input int s, input int n);
    bus.in_valid = v;
    bus.sample   = WIDTH'(s);
    bus.nominal  = WIDTH'(n);
  endtask

  // One cycle: observe the handshakes that the coming edge will perform,
  // then advance to the next falling edge.
  task automatic tick();
    int e;
    #1;
    if (sb_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got abs_dev %0d with empty expectation queue", bus.abs_dev);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if (e > mpeak) mpeak = e;
        if (e > thr) mrun++; else mrun = 0;
        if (mrun >= int'(HOLD)) malarm = 1;
        chk("sb_abs_dev", int'(bus.abs_dev), e);
        chk("sb_over", int'(bus.over), int'(e > thr));
        chk("sb_peak", int'(bus.peak), mpeak);
        chk("sb_alarm", int'(bus.alarm), malarm);
        alarm_log.push_back(int'(bus.alarm));
      end
    end
    if (sb_en && bus.in_valid && bus.in_ready)
      exp_q.push_back(absdev(int'($signed(bus.sample)), int'($signed(bus.nominal))));
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    drive(0, 0, 0);
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int cyc;
    int vals[10];
    int s_abs, s_peak, s_alarm, s_over;
    bit stalled;
    bit acc;
    int exp_alarm[7];

    tbl[0] = '{10,    3,   5,   7, 1,   7};
    tbl[1] = '{3,    10,   5,   7, 1,   7};
    tbl[2] = '{5,     0,   5,   5, 0,   7};
    tbl[3] = '{6,     0,   5,   6, 1,   7};
    tbl[4] = '{-128, 127, 254, 255, 1, 255};
    tbl[5] = '{127, -128, 255, 255, 0, 255};
    tbl[6] = '{-128,  0, 100, 128, 1, 255};
    tbl[7] = '{-1,   -1,   0,   0, 0, 255};
    exp_alarm = '{0, 0, 0, 0, 0, 1, 1};

    sb_en = 1'b0;
    thr   = 0;
    model_reset();
    drive(0, 0, 0);
    bus.threshold = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_alarm", int'(bus.alarm), 0);
    chk("rst_peak", int'(bus.peak), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single-sample transactions with latency check
    for (int i = 0; i < 8; i++) begin
      bus.threshold = WIDTH'(tbl[i].th);
      drive(1, tbl[i].s, tbl[i].n);
      tick();
      drive(0, 0, 0);
      chk($sformatf("vec%0d_valid_early", i), int'(bus.out_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
      chk($sformatf("vec%0d_abs_dev", i), int'(bus.abs_dev), tbl[i].exp_abs);
      chk($sformatf("vec%0d_over", i), int'(bus.over), tbl[i].exp_over);
      chk($sformatf("vec%0d_peak", i), int'(bus.peak), tbl[i].exp_peak);
      tick();
    end

    // Clear while idle
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("idle_clear_alarm", int'(bus.alarm), 0);
    chk("idle_clear_peak", int'(bus.peak), 0);

    // Consecutive-over alarm sequence, back-to-back
    model_reset();
    sb_en = 1'b1;
    thr   = 5;
    bus.threshold = 8'd5;
    foreach (exp_alarm[i]) begin
      case (i)
        2:       drive(1, 2, 0);
        6:       drive(1, 0, 0);
        default: drive(1, 0, 6);
      endcase
      tick();
    end
    drain("alarm_seq");
    chk("alarm_seq_count", alarm_log.size(), 7);
    foreach (exp_alarm[i])
      if (i < alarm_log.size()) chk($sformatf("alarm_seq_r%0d", i), alarm_log[i], exp_alarm[i]);
    chk("alarm_sticky_idle", int'(bus.alarm), 1);

    // Clear coinciding with a valid stage-2 load
    sb_en = 1'b0;
    drive(1, 9, 0);
    tick();
    drive(0, 0, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_alarm", int'(bus.alarm), 0);
    chk("clr_peak", int'(bus.peak), 0);
    chk("clr_abs_dev", int'(bus.abs_dev), 9);
    chk("clr_out_valid", int'(bus.out_valid), 1);
    tick();
    drive(1, -4, 0);
    tick();
    drive(0, 0, 0);
    tick();
    chk("post_clr_abs_dev", int'(bus.abs_dev), 4);
    chk("post_clr_peak", int'(bus.peak), 4);
    chk("post_clr_alarm", int'(bus.alarm), 0);
    tick();

    // Asynchronous reset with two samples in flight
    drive(1, 20, 0);
    tick();
    drive(1, 30, 0);
    tick();
    drive(0, 0, 0);
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_abs_dev", int'(bus.abs_dev), 0);
    chk("mid_rst_over", int'(bus.over), 0);
    chk("mid_rst_peak", int'(bus.peak), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_no_stale%0d", i), int'(bus.out_valid), 0);
    end

    // Backpressure: 10-sample stream with a 3-cycle output stall
    model_reset();
    sb_en = 1'b1;
    foreach (vals[i]) vals[i] = int'($urandom_range(0, 255)) - 128;
    idx = 0;
    cyc = 0;
    s_abs = 0; s_peak = 0; s_alarm = 0; s_over = 0;
    while (idx < 10 && cyc < 100) begin
      drive(1, vals[idx], 0);
      bus.out_ready = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
      #1;
      stalled = bus.out_valid && !bus.out_ready;
      acc     = bus.in_ready;
      if (stalled) begin
        chk("bp_in_ready", int'(bus.in_ready), 0);
        s_abs   = int'(bus.abs_dev);
        s_peak  = int'(bus.peak);
        s_alarm = int'(bus.alarm);
        s_over  = int'(bus.over);
      end
      tick();
      if (stalled) begin
        chk("bp_hold_valid", int'(bus.out_valid), 1);
        chk("bp_hold_abs", int'(bus.abs_dev), s_abs);
        chk("bp_hold_over", int'(bus.over), s_over);
        chk("bp_hold_peak", int'(bus.peak), s_peak);
        chk("bp_hold_alarm", int'(bus.alarm), s_alarm);
      end
      if (acc) idx++;
      cyc++;
    end
    chk("bp_all_sent", idx, 10);
    drain("bp");
    chk("bp_result_count", pops, 10);

    // Randomized traffic against the scoreboard
    thr = int'($urandom_range(40, 120));
    bus.threshold = WIDTH'(thr);
    drive(0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      if (!bus.in_valid || acc)
        drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      bus.out_ready = bit'($urandom_range(0, 3) != 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
